// File: rtl/rng_pkg.sv
// Shared types and default parameters for the random word harvester.
package rng_pkg;

    typedef enum logic {
        FIRST  = 1'b0,
        SECOND = 1'b1
    } vn_state_t;

    localparam int DEF_WIDTH      = 16;
    localparam int DEF_SAMPLE_DIV = 4;
    localparam int DEF_REP_LIMIT  = 64;

endpackage

// File: rtl/von_neumann_debias.sv
// Von Neumann pair extractor: emits the first bit of every unequal sample pair.
module von_neumann_debias
    import rng_pkg::*;
(
    input  logic CLK,
    input  logic RST,
    input  logic strobe,
    input  logic s,
    input  logic clear,
    output logic dbit,
    output logic dbit_valid
);

    vn_state_t state;
    logic      first;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= FIRST;
            first <= 1'b0;
        end else if (clear) begin
            state <= FIRST;
            first <= 1'b0;
        end else if (strobe) begin
            case (state)
                FIRST: begin
                    first <= s;
                    state <= SECOND;
                end
                default: state <= FIRST;
            endcase
        end
    end

    // The pair completes on the strobe edge itself, so the bit is offered combinationally.
    assign dbit       = first;
    assign dbit_valid = strobe && !clear && (state == SECOND) && (s != first);

endmodule

// File: rtl/random_word_harvester.sv
// Samples a metastable entropy bit, debiases it, packs WIDTH-bit words onto a
// valid/ready stream and latches a sticky fault when the source sticks.
module random_word_harvester
    import rng_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int SAMPLE_DIV = DEF_SAMPLE_DIV,
    parameter int REP_LIMIT  = DEF_REP_LIMIT
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             raw_bit,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             fault,
    output logic             words_dropped
);

    localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int REP_W = $clog2(REP_LIMIT + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [REP_W-1:0] REP_MAX  = REP_W'(REP_LIMIT);

    logic             sync1;
    logic             s;
    logic [DIV_W-1:0] div;
    logic             strobe;
    logic             prev;
    logic [REP_W-1:0] rep_cnt;
    logic [REP_W-1:0] rep_next;
    logic             fault_next;
    logic             dbit;
    logic             dbit_valid;
    logic [WIDTH-1:0] acc;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] word;
    logic             out_free;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync1 <= 1'b0;
            s     <= 1'b0;
        end else begin
            sync1 <= raw_bit;
            s     <= sync1;
        end
    end

    assign strobe = (div == DIV_LAST);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            div <= '0;
        end else if (strobe) begin
            div <= '0;
        end else begin
            div <= div + 1'b1;
        end
    end

    // rep_cnt==0 marks "no previous sample yet"; the first sample just seeds prev.
    always_comb begin
        rep_next = rep_cnt;
        if (strobe) begin
            if ((rep_cnt == '0) || (s != prev)) begin
                rep_next = REP_W'(1);
            end else if (rep_cnt != REP_MAX) begin
                rep_next = rep_cnt + 1'b1;
            end
        end
        fault_next = fault || (rep_next == REP_MAX);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            prev    <= 1'b0;
            rep_cnt <= '0;
            fault   <= 1'b0;
        end else begin
            if (strobe) begin
                prev <= s;
            end
            rep_cnt <= rep_next;
            fault   <= fault_next;
        end
    end

    von_neumann_debias u_debias (
        .CLK       (CLK),
        .RST       (RST),
        .strobe    (strobe),
        .s         (s),
        .clear     (fault_next),
        .dbit      (dbit),
        .dbit_valid(dbit_valid)
    );

    // Handshake: a word transfers on any edge where out_valid && out_ready; out_data
    // is held while out_valid && !out_ready, and a new word may load on the transfer edge.
    assign out_free = !out_valid || out_ready;
    assign word     = {acc[WIDTH-2:0], dbit};

    // count==WIDTH means acc holds a complete word waiting for the output register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            acc           <= '0;
            count         <= '0;
            out_data      <= '0;
            out_valid     <= 1'b0;
            words_dropped <= 1'b0;
        end else if (fault_next) begin
            acc           <= '0;
            count         <= '0;
            out_data      <= '0;
            out_valid     <= 1'b0;
            words_dropped <= 1'b0;
        end else begin
            words_dropped <= 1'b0;
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (count == CNT_FULL) begin
                if (out_free) begin
                    out_data  <= acc;
                    out_valid <= 1'b1;
                    if (dbit_valid) begin
                        acc   <= WIDTH'(dbit);
                        count <= CNT_W'(1);
                    end else begin
                        count <= '0;
                    end
                end else if (dbit_valid) begin
                    words_dropped <= 1'b1;
                end
            end else if (dbit_valid) begin
                if (count == CNT_LAST) begin
                    if (out_free) begin
                        out_data  <= word;
                        out_valid <= 1'b1;
                        count     <= '0;
                    end else begin
                        acc   <= word;
                        count <= CNT_FULL;
                    end
                end else begin
                    acc   <= word;
                    count <= count + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_random_word_harvester.sv
// Bench for random_word_harvester: two configurations checked against a queue-free
// sample/pair/word model every cycle, plus directed literal expectations.
`timescale 1ns/1ps
module tb_random_word_harvester;

    localparam int WA = 8;
    localparam int DA = 1;
    localparam int RA = 8;
    localparam int WB = 16;
    localparam int DB = 4;
    localparam int RB = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_a = 1'b1, raw_a = 1'b0, ready_a = 1'b1;
    logic [WA-1:0] data_a;
    logic          valid_a, fault_a, drop_a;
    logic          rst_b = 1'b1, raw_b = 1'b0, ready_b = 1'b1;
    logic [WB-1:0] data_b;
    logic          valid_b, fault_b, drop_b;

    random_word_harvester #(.WIDTH(WA), .SAMPLE_DIV(DA), .REP_LIMIT(RA)) dut_a (
        .CLK(clk), .RST(rst_a), .raw_bit(raw_a), .out_data(data_a), .out_valid(valid_a),
        .out_ready(ready_a), .fault(fault_a), .words_dropped(drop_a)
    );

    random_word_harvester #(.WIDTH(WB), .SAMPLE_DIV(DB), .REP_LIMIT(RB)) dut_b (
        .CLK(clk), .RST(rst_b), .raw_bit(raw_b), .out_data(data_b), .out_valid(valid_b),
        .out_ready(ready_b), .fault(fault_b), .words_dropped(drop_b)
    );

    int tests_run    = 0;
    int tests_failed = 0;
    int drop_cnt_a   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model (index 0 = dut_a, 1 = dut_b) ----------------
    logic        m_s1[2], m_s[2], m_have_first[2], m_first[2], m_prev[2];
    logic        m_fault[2], m_valid[2], m_drop[2], m_held[2];
    int          m_tick[2], m_run[2], m_nbits[2];
    logic [31:0] m_acc[2], m_held_word[2], m_data[2];

    task automatic model_reset(input int i);
        m_s1[i] = 0; m_s[i] = 0; m_have_first[i] = 0; m_first[i] = 0; m_prev[i] = 0;
        m_fault[i] = 0; m_valid[i] = 0; m_drop[i] = 0; m_held[i] = 0;
        m_tick[i] = 0; m_run[i] = 0; m_nbits[i] = 0;
        m_acc[i] = 0; m_held_word[i] = 0; m_data[i] = 0;
    endtask

    task automatic model_step(input int i, input logic raw, input logic rdy);
        int   w, div, lim;
        logic smp, strobe, dv, d, free;
        w   = (i == 0) ? WA : WB;
        div = (i == 0) ? DA : DB;
        lim = (i == 0) ? RA : RB;
        smp = m_s[i];
        m_s[i]  = m_s1[i];
        m_s1[i] = raw;
        strobe = ((m_tick[i] % div) == div - 1);
        m_tick[i]++;
        m_drop[i] = 0;
        if (m_fault[i]) return;
        dv = 0;
        d  = 0;
        if (strobe) begin
            if (m_run[i] == 0 || smp != m_prev[i]) m_run[i] = 1;
            else if (m_run[i] < lim) m_run[i]++;
            m_prev[i] = smp;
            if (m_run[i] >= lim) begin
                m_fault[i] = 1; m_valid[i] = 0; m_data[i] = 0; m_held[i] = 0;
                m_nbits[i] = 0; m_acc[i] = 0; m_have_first[i] = 0;
                return;
            end
            if (!m_have_first[i]) begin
                m_have_first[i] = 1;
                m_first[i] = smp;
            end else begin
                m_have_first[i] = 0;
                if (smp != m_first[i]) begin
                    dv = 1;
                    d  = m_first[i];
                end
            end
        end
        free = !m_valid[i] || rdy;
        if (m_valid[i] && rdy) m_valid[i] = 0;
        if (m_held[i] && free) begin
            m_data[i] = m_held_word[i];
            m_valid[i] = 1;
            m_held[i] = 0;
            if (dv) begin
                m_acc[i] = {31'd0, d};
                m_nbits[i] = 1;
            end
        end else if (dv) begin
            if (m_held[i]) begin
                m_drop[i] = 1;
            end else begin
                m_acc[i] = (m_acc[i] << 1) | {31'd0, d};
                m_nbits[i]++;
                if (m_nbits[i] == w) begin
                    if (free) begin
                        m_data[i] = m_acc[i];
                        m_valid[i] = 1;
                    end else begin
                        m_held[i] = 1;
                        m_held_word[i] = m_acc[i];
                    end
                    m_acc[i] = 0;
                    m_nbits[i] = 0;
                end
            end
        end
    endtask

    always @(posedge clk or posedge rst_a) begin
        if (rst_a) model_reset(0);
        else model_step(0, raw_a, ready_a);
    end

    always @(posedge clk or posedge rst_b) begin
        if (rst_b) model_reset(1);
        else model_step(1, raw_b, ready_b);
    end

    always @(negedge clk) begin
        check("a_valid", valid_a, m_valid[0]);
        check("a_fault", fault_a, m_fault[0]);
        check("a_drop", drop_a, m_drop[0]);
        if (m_valid[0]) check("a_data", data_a, m_data[0]);
        check("b_valid", valid_b, m_valid[1]);
        check("b_fault", fault_b, m_fault[1]);
        check("b_drop", drop_b, m_drop[1]);
        if (m_valid[1]) check("b_data", data_b, m_data[1]);
        if (drop_a) drop_cnt_a++;
    end

    // ---------------- driver tasks ----------------
    task automatic drive_a(input logic v);
        raw_a = v;
        @(posedge clk);
        #2;
    endtask

    task automatic send_bit_a(input logic b);
        drive_a(b);
        drive_a(~b);
    endtask

    task automatic send_byte_a(input logic [7:0] w);
        for (int k = 7; k >= 0; k--) send_bit_a(w[k]);
    endtask

    task automatic reset_a();
        @(posedge clk);
        #2;
        rst_a = 1'b1;
        @(posedge clk);
        #2;
        rst_a = 1'b0;
    endtask

    task automatic wait_valid_a(input int budget, output logic got);
        got = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(posedge clk);
            #1;
            if (valid_a) begin
                got = 1'b1;
                break;
            end
        end
        #1;
    endtask

    logic [0:19] pat2 = 20'b01101001110001101001;

    initial begin
        logic got;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid_a", valid_a, 0);
        check("rst_data_a", data_a, 0);
        check("rst_fault_b", fault_b, 0);
        check("rst_data_b", data_b, 0);
        #1;

        // Basic word: pairs 01,10,10,01,11,00,01,10,10,01 -> 8'b01100110
        ready_a = 1'b1;
        reset_a();
        for (int j = 0; j < 20; j++) drive_a(pat2[j]);
        @(posedge clk);
        #1;
        check("word_early", valid_a, 0);
        @(posedge clk);
        #1;
        check("word_valid", valid_a, 1);
        check("word_data", data_a, 8'h66);
        #1;

        // Backpressure: two words then five more bits with out_ready low
        ready_a = 1'b0;
        reset_a();
        send_byte_a(8'hB4);
        send_byte_a(8'h3C);
        drop_cnt_a = 0;
        repeat (5) send_bit_a(1'b1);
        repeat (3) @(posedge clk);
        #1;
        check("bp_drops", drop_cnt_a, 5);
        check("bp_valid", valid_a, 1);
        check("bp_word1", data_a, 8'hB4);
        #1;
        ready_a = 1'b1;
        @(posedge clk);
        #1;
        check("bp_word2_valid", valid_a, 1);
        check("bp_word2", data_a, 8'h3C);
        @(posedge clk);
        #1;
        check("bp_drained", valid_a, 0);
        #1;

        // Asynchronous reset with a held word and a partial word (count=7)
        ready_a = 1'b0;
        reset_a();
        send_byte_a(8'h5A);
        repeat (7) send_bit_a(1'b1);
        repeat (2) @(posedge clk);
        #1;
        check("pre_rst_valid", valid_a, 1);
        check("pre_rst_data", data_a, 8'h5A);
        @(negedge clk);
        #1;
        rst_a = 1'b1;
        #1;
        check("async_rst_valid", valid_a, 0);
        check("async_rst_data", data_a, 0);
        check("async_rst_drop", drop_a, 0);
        repeat (3) begin
            @(posedge clk);
            #2;
            raw_a = ~raw_a;
        end
        rst_a = 1'b0;
        ready_a = 1'b1;
        send_byte_a(8'hC3);
        wait_valid_a(10, got);
        check("post_rst_got_word", got, 1);
        check("post_rst_word", data_a, 8'hC3);

        // Health test: stuck-at-1 trips on the 8th identical sample
        reset_a();
        raw_a = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            #1;
            if (k == 9) check("fault_before", fault_a, 0);
            if (k == 10) begin
                check("fault_set", fault_a, 1);
                check("fault_valid", valid_a, 0);
            end
        end
        #1;
        repeat (16) begin
            raw_a = ~raw_a;
            @(posedge clk);
            #2;
        end
        check("fault_sticky", fault_a, 1);
        check("fault_no_valid", valid_a, 0);

        // Fault discards a pending word
        ready_a = 1'b0;
        reset_a();
        send_byte_a(8'hA5);
        wait_valid_a(6, got);
        check("pend_word_got", got, 1);
        raw_a = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (fault_a) begin
                got = 1'b1;
                break;
            end
        end
        check("pend_fault_got", got, 1);
        check("pend_discarded", valid_a, 0);
        #1;
        rst_a = 1'b1;

        // Divider: SAMPLE_DIV=4, raw toggling every 4 clocks -> one word per 128 clocks
        @(posedge clk);
        #2;
        rst_b = 1'b0;
        raw_b = 1'b1;
        ready_b = 1'b1;
        for (int k = 1; k <= 260; k++) begin
            @(posedge clk);
            #1;
            if (k == 127) check("div_w1_early", valid_b, 0);
            if (k == 128) begin
                check("div_w1_valid", valid_b, 1);
                check("div_w1_data", data_b, 16'hFFFF);
            end
            if (k == 129) check("div_w1_taken", valid_b, 0);
            if (k == 255) check("div_w2_early", valid_b, 0);
            if (k == 256) begin
                check("div_w2_valid", valid_b, 1);
                check("div_w2_data", data_b, 16'hFFFF);
            end
            #1;
            if (k % 4 == 0) raw_b = ~raw_b;
        end
        check("div_no_fault", fault_b, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, failures so far %0d", tests_failed);
        $fatal(1, "watchdog");
    end

endmodule
